// File: rtl/mod_mapper.sv
// Constellation mapper: buffers 4-bit nibbles and serialises them LSB first into
// BPSK / QPSK / 16-QAM symbols, emitted as signed I/Q samples on a registered stage.
module mod_mapper #(
  parameter int OUT_W = 4,
  parameter int AMP   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [3:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    mode_err
);

  // Handshakes: a transfer happens on a rising clk edge when valid && ready are both
  // high; a source holds its payload stable while valid=1 and ready=0.

  localparam logic signed [OUT_W-1:0] LVL_P1 = OUT_W'(AMP);
  localparam logic signed [OUT_W-1:0] LVL_N1 = OUT_W'(-AMP);
  localparam logic signed [OUT_W-1:0] LVL_P3 = OUT_W'(3 * AMP);
  localparam logic signed [OUT_W-1:0] LVL_N3 = OUT_W'(-3 * AMP);

  logic [3:0] bit_buf;
  logic [2:0] cnt;
  logic [1:0] mode_q;
  logic [2:0] bps;
  logic       can_load;
  logic       emit;
  logic       load;
  logic signed [OUT_W-1:0] i_next;
  logic signed [OUT_W-1:0] q_next;

  function automatic logic signed [OUT_W-1:0] bpsk_lvl(input logic b);
    return b ? LVL_N1 : LVL_P1;
  endfunction

  // Gray coded: high bit selects sign, low bit selects inner/outer magnitude.
  function automatic logic signed [OUT_W-1:0] qam_lvl(input logic sgn, input logic mag);
    if (sgn) return mag ? LVL_N3 : LVL_N1;
    else     return mag ? LVL_P3 : LVL_P1;
  endfunction

  always_comb begin
    case (mode_q)
      2'd1:    bps = 3'd2;
      2'd2:    bps = 3'd4;
      default: bps = 3'd1;
    endcase
  end

  always_comb begin
    i_next = bpsk_lvl(bit_buf[0]);
    q_next = '0;
    case (mode_q)
      2'd1: begin
        i_next = bpsk_lvl(bit_buf[0]);
        q_next = bpsk_lvl(bit_buf[1]);
      end
      2'd2: begin
        i_next = qam_lvl(bit_buf[1], bit_buf[0]);
        q_next = qam_lvl(bit_buf[3], bit_buf[2]);
      end
      default: ;
    endcase
  end

  assign can_load = !out_valid || out_ready;
  assign emit     = can_load && (cnt != 3'd0);
  // Accept the next nibble in the same cycle the last symbol leaves the buffer.
  assign in_ready = (cnt == 3'd0) || ((cnt == bps) && emit);
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_buf   <= '0;
      cnt       <= '0;
      mode_q    <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      if (emit) begin
        i_out     <= i_next;
        q_out     <= q_next;
        out_valid <= 1'b1;
        out_last  <= (cnt == bps);
        bit_buf   <= bit_buf >> bps;
        cnt       <= cnt - bps;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (load) begin
        bit_buf  <= in_data;
        cnt      <= 3'd4;
        mode_q   <= mode;
        mode_err <= mode_err | (mode == 2'd3);
      end
    end
  end

endmodule

// File: tb/tb_mod_mapper.sv
// Directed bench for mod_mapper: nibbles are driven in sequence, expected samples are
// queued at acceptance and compared in order as the output stage delivers them.
module tb_mod_mapper;

  localparam int OUT_W = 4;
  localparam int AMP   = 2;
  localparam int SW    = 2 * OUT_W + 1;

  logic                    clk;
  logic                    rst_n;
  logic [1:0]              mode;
  logic [3:0]              in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] i_out;
  logic signed [OUT_W-1:0] q_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    mode_err;

  mod_mapper #(.OUT_W(OUT_W), .AMP(AMP)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .i_out(i_out), .q_out(q_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .mode_err(mode_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [SW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected samples for one nibble.
  task automatic push_model(input logic [1:0] m, input logic [3:0] d);
    int bits, nsym, iv, qv;
    logic [3:0] b;
    logic lst;
    bits = (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
    nsym = 4 / bits;
    for (int k = 0; k < nsym; k++) begin
      b = d >> (k * bits);
      if (m == 2'd2) begin
        iv = b[0] ? 3 * AMP : AMP;
        if (b[1]) iv = -iv;
        qv = b[2] ? 3 * AMP : AMP;
        if (b[3]) qv = -qv;
      end else begin
        iv = b[0] ? -AMP : AMP;
        qv = (m == 2'd1) ? (b[1] ? -AMP : AMP) : 0;
      end
      lst = (k == nsym - 1);
      exp_q.push_back({lst, OUT_W'(iv), OUT_W'(qv)});
    end
  endtask

  // driver tasks
  task automatic send(input logic [1:0] m, input logic [3:0] d);
    logic acc;
    acc = 1'b0;
    mode = m; in_data = d; in_valid = 1'b1;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        push_model(m, d);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("nibble_accepted", 32'(acc), 32'd1);
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // scoreboard monitor: also checks that a stalled sample does not change
  logic [SW-1:0] held;
  logic          held_v = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (held_v && out_valid)
        check("stall_hold", 32'({out_last, i_out, q_out}), 32'(held));
      if (out_valid && out_ready) begin
        check("sample_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check("sample", 32'({out_last, i_out, q_out}), 32'(exp_q.pop_front()));
      end
      held_v = out_valid && !out_ready;
      held   = {out_last, i_out, q_out};
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    int a1;
    rst_n = 1'b0; mode = 2'd0; in_data = 4'd0; in_valid = 1'b0; out_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_i_q", 32'({i_out, q_out}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mode_err", 32'(mode_err), 32'd0);

    // BPSK 0101: latency one edge, in_ready low for three cycles
    send(2'd0, 4'b0101);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bpsk_in_ready", 32'(in_ready), 32'(k == 3));
      check("bpsk_out_valid", 32'(out_valid), 32'(k != 0));
    end
    @(posedge clk); #1;
    idle(3);

    // QPSK 1001 then next nibble taken together with the second emit
    send(2'd1, 4'b1001);
    a1 = acc_cyc;
    send(2'd1, 4'b0110);
    check("qpsk_accept_gap", 32'(acc_cyc - a1), 32'd2);
    idle(4);

    // 16QAM back-to-back nibbles
    send(2'd2, 4'b0111);
    a1 = acc_cyc;
    send(2'd2, 4'b1000);
    check("qam_accept_gap", 32'(acc_cyc - a1), 32'd1);
    @(negedge clk);
    check("qam_stream_v0", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("qam_stream_v1", 32'(out_valid), 32'd1);
    idle(4);

    // backpressure mid-nibble
    send(2'd0, 4'b0011);
    idle(1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    idle(6);

    // mode change mid-nibble, then 16QAM, then reserved mode
    send(2'd1, 4'b1101);
    mode = 2'd2;
    idle(1);
    send(2'd2, 4'b1110);
    idle(3);
    check("mode_err_clear", 32'(mode_err), 32'd0);
    send(2'd3, 4'b1010);
    check("mode_err_set", 32'(mode_err), 32'd1);
    idle(5);
    send(2'd0, 4'b0110);
    idle(5);
    check("mode_err_sticky", 32'(mode_err), 32'd1);
    check("drained_before_reset", 32'(exp_q.size()), 32'd0);

    // asynchronous reset mid-nibble
    send(2'd0, 4'b1111);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_i_q", 32'({i_out, q_out, out_last}), 32'd0);
    check("async_rst_mode_err", 32'(mode_err), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(2'd1, 4'b0011);

    // drain with a bounded wait
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
    idle(2);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_mapper.md
Name: mod_mapper

Overview:
- Parametrised constellation mapper; next generation of the fixed single-mode BPSK mapper.
- Accepts 4-bit nibbles over a valid/ready handshake and buffers them internally.
- Serialises each nibble into BPSK, QPSK or 16-QAM symbols (1/2/4 bits per symbol), LSB first.
- Emits signed I/Q samples over a registered valid/ready output stage; sits between the bit source and the pulse-shaping/DAC path.

Parameters:
- OUT_W, 4: signed width of i_out/q_out.
- AMP, 2: unit amplitude A. Inner level = A, outer level = 3A. Constraint: 3*AMP <= 2^(OUT_W-1)-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  2  0=BPSK, 1=QPSK, 2=16QAM, 3=reserved
- in_data  in  4  input nibble, bit0 consumed first
- in_valid  in  1  in_data valid
- in_ready  out  1  mapper can accept a nibble this cycle
- i_out  out  OUT_W  signed I sample (registered)
- q_out  out  OUT_W  signed Q sample (registered)
- out_valid  out  1  i_out/q_out valid
- out_ready  in  1  downstream accepts sample
- out_last  out  1  sample is the final symbol of its nibble
- mode_err  out  1  sticky: a nibble was loaded with mode=3

Behaviour:
- State:
  - buf[3:0]: bit buffer.
  - cnt (0..4): bits remaining in buf.
  - mode_q: mode latched at nibble load.
  - bps: bits per symbol of mode_q; 1/2/4, reserved maps to 1.
- Reset values (async on rst_n low): buf=0, cnt=0, mode_q=0, i_out=0, q_out=0, out_valid=0, out_last=0, mode_err=0. Reset mid-nibble discards all buffered bits and any pending output.
- Output stage:
  - Can load when out_valid=0 or out_ready=1 (slot free or draining).
  - Emit condition: stage can load and cnt>0.
  - On emit:
    - i_out/q_out <= map(buf low bits).
    - out_valid <= 1.
    - out_last <= (cnt==bps).
    - buf <= buf >> bps.
    - cnt <= cnt - bps.
  - If out_valid && out_ready and no emit: out_valid <= 0.
  - i_out/q_out/out_last hold while out_valid=1 and out_ready=0.
- in_ready (combinational) = (cnt==0) || (cnt==bps && emit this cycle).
- Nibble load on in_valid && in_ready:
  - buf <= in_data, cnt <= 4, mode_q <= mode.
  - mode_err <= mode_err | (mode==3).
  - Load overrides the emit's buf/cnt update in the same cycle.
- Latency: nibble accepted in cycle N, first sample out_valid in cycle N+1.
- Throughput with out_ready=1 and a continuous input stream: one sample per cycle, no bubbles at nibble boundaries.
- Mode changes take effect only at the next nibble load. mode_q is stable for the whole nibble.
- Mapping, with f(b) = +A if b=0, -A if b=1:
  - BPSK: I = f(b0), Q = 0.
  - QPSK: I = f(b0), Q = f(b1).
  - 16QAM: I from (b1,b0), Q from (b3,b2). High bit = sign (0 positive, 1 negative); low bit = magnitude (0 gives A, 1 gives 3A). Gray: 00=+A, 01=+3A, 11=-3A, 10=-A.
  - Reserved mode: identical to BPSK.
- Arithmetic: levels are computed at full precision and sign-extended to OUT_W. No saturation is needed given the parameter constraint.
- Sample count per nibble: exactly 4/bps. out_last=1 on the final sample only.

Test Plan:
- Reset, then BPSK with in_data=4'b0101 and out_ready=1 -> I = -2,+2,-2,+2 on 4 consecutive cycles; Q=0; out_last on the 4th; in_ready low during cycles 1-3.
- QPSK with in_data=4'b1001 -> (I,Q) = (-2,+2) then (+2,-2); out_last on the 2nd; next nibble accepted in the same cycle as the 2nd emit.
- 16QAM streaming 4'b0111 then 4'b1000 with in_valid held -> (-6,+6) then (+2,-2) on consecutive cycles; out_last=1 on both.
- Backpressure: out_ready=0 for 3 cycles mid-BPSK nibble -> out_valid and sample held stable, no bits lost; resumes in order once out_ready=1.
- Mode switched from QPSK to 16QAM after the first QPSK symbol -> remaining symbol still QPSK; next nibble mapped as 16QAM. mode=3 load -> BPSK output, mode_err=1 and stays set until reset.
- rst_n asserted asynchronously mid-nibble -> outputs 0 immediately; after release, in_ready=1 and no stale samples are emitted.
